// File: rtl/haar_eval_pkg.sv
// Shared widths, parameter-word indices and state encoding for the
// Haar stage evaluator. HAAR_EVAL_SATURATE_EN selects a clamping stage sum.
package haar_eval_pkg;

  localparam int DATA_WIDTH_12 = 12;
  localparam int II_WIDTH = 24;
  localparam int FEAT_WIDTH = 40;
  localparam int SUM_WIDTH = 20;
  localparam int NUM_PARAM_PER_CLASSIFIER = 18;

  localparam int P_RECT_STRIDE = 5;
  localparam int P_RECT0_X = 0;
  localparam int P_RECT0_Y = 1;
  localparam int P_RECT0_W = 2;
  localparam int P_RECT0_H = 3;
  localparam int P_RECT0_WT = 4;
  localparam int P_RECT1_X = 5;
  localparam int P_RECT2_X = 10;
  localparam int P_THR = 15;
  localparam int P_LEFT = 16;
  localparam int P_RIGHT = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_EVAL,
    ST_STAGE_THR
  } state_t;

  // Signed add of two stage-sum words; clamps to the
  // representable range when saturation is built in.
  function automatic logic [SUM_WIDTH-1:0] sum_add(
    input logic [SUM_WIDTH-1:0] a,
    input logic [SUM_WIDTH-1:0] b
  );
    logic [SUM_WIDTH:0] s;
    s = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
`ifdef HAAR_EVAL_SATURATE_EN
    if (s[SUM_WIDTH] != s[SUM_WIDTH-1]) begin
      if (s[SUM_WIDTH])
        return {1'b1, {(SUM_WIDTH-1){1'b0}}};
      else
        return {1'b0, {(SUM_WIDTH-1){1'b1}}};
    end
`endif
    return s[SUM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/haar_rect_sum.sv
// Reads corners A,B,C,D of one rectangle and returns D-B-C+A (24b wrap).
// Ports: start/x/y/w/h in, ii_req/ii_x/ii_y/ii_valid/ii_data, done/sum out.
module haar_rect_sum
  import haar_eval_pkg::*;
(
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     start,
  input  logic [DATA_WIDTH_12-1:0] x,
  input  logic [DATA_WIDTH_12-1:0] y,
  input  logic [DATA_WIDTH_12-1:0] w,
  input  logic [DATA_WIDTH_12-1:0] h,
  output logic                     ii_req,
  output logic [DATA_WIDTH_12-1:0] ii_x,
  output logic [DATA_WIDTH_12-1:0] ii_y,
  input  logic                     ii_valid,
  input  logic [II_WIDTH-1:0]      ii_data,
  output logic                     done,
  output logic [II_WIDTH-1:0]      sum
);

  logic                busy;
  logic [1:0]          corner;
  logic [II_WIDTH-1:0] acc;
  logic [II_WIDTH-1:0] acc_nxt;

  // corner 0=A, 1=B, 2=C, 3=D: bit0 adds w, bit1 adds h
  assign ii_req = busy;
  assign ii_x = !busy ? '0 : corner[0] ? x + w : x;
  assign ii_y = !busy ? '0 : corner[1] ? y + h : y;
  assign sum = acc;

  always_comb begin
    acc_nxt = acc - ii_data;
    if (corner == 2'd0 || corner == 2'd3)
      acc_nxt = acc + ii_data;
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      busy <= 1'b0;
      corner <= '0;
      acc <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        corner <= '0;
        acc <= '0;
      end else if (busy && ii_valid) begin
        acc <= acc_nxt;
        corner <= corner + 2'd1;
        if (corner == 2'd3) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/haar_stage_evaluator.sv
// Evaluates one cascade stage for a window: loads classifiers, sums
// weighted rects, picks leaves, compares with stage threshold.
// Ports: i_start/i_win_*, i_data stream (o_rden), ii port, o_busy/o_done/o_pass/o_stage_sum.
// Build option: HAAR_EVAL_SATURATE_EN makes the stage sum saturate.
module haar_stage_evaluator
  import haar_eval_pkg::*;
(
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_start,
  input  logic [DATA_WIDTH_12-1:0] i_win_x,
  input  logic [DATA_WIDTH_12-1:0] i_win_y,
  input  logic [DATA_WIDTH_12-1:0] i_data,
  input  logic                     i_data_valid,
  input  logic                     i_end_database,
  output logic                     o_rden,
  output logic                     o_ii_req,
  output logic [DATA_WIDTH_12-1:0] o_ii_x,
  output logic [DATA_WIDTH_12-1:0] o_ii_y,
  input  logic                     i_ii_valid,
  input  logic [II_WIDTH-1:0]      i_ii_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [SUM_WIDTH-1:0]     o_stage_sum
);

  state_t state, state_d;

  logic [DATA_WIDTH_12-1:0] params [NUM_PARAM_PER_CLASSIFIER];
  logic [4:0] cnt;
  logic [1:0] rect;
  logic       launched;
  logic [DATA_WIDTH_12-1:0] win_x, win_y;
  logic signed [FEAT_WIDTH-1:0] feature;
  logic [SUM_WIDTH-1:0] stage_sum;

  logic rs_start, rs_done;
  logic [II_WIDTH-1:0] rs_sum;
  logic load_word, finish, rect_adv, skip, pass_d;
  logic [4:0] base;
  logic [DATA_WIDTH_12-1:0] rx, ry, rw, rh, rwt, leaf;
  logic signed [FEAT_WIDTH-1:0] wt_ext, rs_ext, prod, thr_ext;
  logic signed [SUM_WIDTH-1:0] sum_s, sthr_s;

  assign base = 5'(rect) * 5'(P_RECT_STRIDE);
  assign rx = win_x + params[base];
  assign ry = win_y + params[base + 5'd1];
  assign rw = params[base + 5'd2];
  assign rh = params[base + 5'd3];
  assign rwt = params[base + 5'd4];
  assign skip = (rwt == '0) || (rw == '0) || (rh == '0);

  assign wt_ext = FEAT_WIDTH'(signed'(rwt));
  assign rs_ext = FEAT_WIDTH'(rs_sum);
  assign prod = wt_ext * rs_ext;

  assign thr_ext = FEAT_WIDTH'(signed'(params[P_THR]));
  assign leaf = (feature < thr_ext) ? params[P_LEFT] : params[P_RIGHT];

  assign sum_s = stage_sum;
  assign sthr_s = SUM_WIDTH'(signed'(i_data));
  assign pass_d = sum_s >= sthr_s;

  assign o_busy = state != ST_IDLE;

  haar_rect_sum u_rect (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .start      (rs_start),
    .x          (rx),
    .y          (ry),
    .w          (rw),
    .h          (rh),
    .ii_req     (o_ii_req),
    .ii_x       (o_ii_x),
    .ii_y       (o_ii_y),
    .ii_valid   (i_ii_valid),
    .ii_data    (i_ii_data),
    .done       (rs_done),
    .sum        (rs_sum)
  );

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    o_rden = 1'b0;
    rs_start = 1'b0;
    load_word = 1'b0;
    finish = 1'b0;
    rect_adv = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start)
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_rden = i_data_valid;
        // end marker at a classifier boundary is the stage threshold
        if (cnt == '0 && i_end_database) begin
          if (i_data_valid) begin
            finish = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STAGE_THR;
          end
        end else if (i_data_valid) begin
          load_word = 1'b1;
          if (cnt == 5'(NUM_PARAM_PER_CLASSIFIER - 1))
            state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (skip || rs_done) begin
          rect_adv = 1'b1;
          if (rect == 2'd2)
            state_d = ST_EVAL;
        end else if (!launched) begin
          rs_start = 1'b1;
        end
      end
      ST_EVAL: state_d = ST_LOAD;
      ST_STAGE_THR: begin
        o_rden = i_data_valid;
        if (i_data_valid) begin
          finish = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      cnt <= '0;
      rect <= '0;
      launched <= 1'b0;
      win_x <= '0;
      win_y <= '0;
      feature <= '0;
      stage_sum <= '0;
      o_done <= 1'b0;
      o_pass <= 1'b0;
      o_stage_sum <= '0;
      for (int i = 0; i < NUM_PARAM_PER_CLASSIFIER; i++)
        params[i] <= '0;
    end else begin
      o_done <= finish;
      if (state == ST_IDLE && i_start) begin
        win_x <= i_win_x;
        win_y <= i_win_y;
        stage_sum <= '0;
        cnt <= '0;
        o_pass <= 1'b0;
        o_stage_sum <= '0;
      end
      if (load_word) begin
        params[cnt] <= i_data;
        if (cnt == 5'(NUM_PARAM_PER_CLASSIFIER - 1)) begin
          cnt <= '0;
          rect <= '0;
          launched <= 1'b0;
          feature <= '0;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
      if (rs_start)
        launched <= 1'b1;
      if (rect_adv) begin
        rect <= (rect == 2'd2) ? 2'd0 : rect + 2'd1;
        launched <= 1'b0;
        if (!skip)
          feature <= feature + prod;
      end
      if (state == ST_EVAL)
        stage_sum <= sum_add(stage_sum, SUM_WIDTH'(signed'(leaf)));
      if (finish) begin
        o_pass <= pass_d;
        o_stage_sum <= stage_sum;
      end
    end
  end

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Scoreboard bench for haar_stage_evaluator: stream classifiers,
// answer integral-image reads, compare stage results.
module tb_haar_stage_evaluator;

  logic        clk_fpga = 0;
  logic        reset_fpga = 0;
  logic        i_start = 0;
  logic [11:0] i_win_x = 0, i_win_y = 0, i_data = 0;
  logic        i_data_valid = 0, i_end_database = 0;
  logic        o_rden, o_ii_req;
  logic [11:0] o_ii_x, o_ii_y;
  logic        i_ii_valid = 0;
  logic [23:0] i_ii_data = 0;
  logic        o_busy, o_done, o_pass;
  logic [19:0] o_stage_sum;

  typedef logic [11:0] cls_t [18];
  typedef struct { logic pass; logic [19:0] sum; } exp_t;

  exp_t sb[$];
  cls_t cls_q[$];
  int n_cmp = 0, n_bad = 0;
  int hs_cnt = 0, done_cnt = 0, rden_viol = 0, dly = 0;

  cls_t cls_a = '{12'd1, 12'd1, 12'd2, 12'd2, 12'd1,
                  12'd0, 12'd0, 12'd5, 12'd5, 12'd0,
                  12'd2, 12'd3, 12'd1, 12'd4, 12'd0,
                  12'd50, 12'hFFB, 12'd7};
  cls_t cls_a2 = '{12'd1, 12'd1, 12'd2, 12'd2, 12'hFFD,
                   12'd1, 12'd2, 12'd3, 12'd4, 12'd0,
                   12'd0, 12'd1, 12'd2, 12'd2, 12'd0,
                   12'hF00, 12'd100, 12'hFF7};
  cls_t cls_b = '{12'd0, 12'd0, 12'd3, 12'd1, 12'hFFE,
                  12'd2, 12'd2, 12'd1, 12'd1, 12'd3,
                  12'd1, 12'd0, 12'd0, 12'd4, 12'd5,
                  12'd100, 12'd300, 12'hFEC};
  cls_t cls_s = '{12'd0, 12'd0, 12'd1, 12'd1, 12'd0,
                  12'd0, 12'd0, 12'd1, 12'd1, 12'd0,
                  12'd0, 12'd0, 12'd1, 12'd1, 12'd0,
                  12'd0, 12'd0, 12'h7FF};

  always #5 clk_fpga = ~clk_fpga;

  haar_stage_evaluator dut (
    .clk_fpga       (clk_fpga),
    .reset_fpga     (reset_fpga),
    .i_start        (i_start),
    .i_win_x        (i_win_x),
    .i_win_y        (i_win_y),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .i_end_database (i_end_database),
    .o_rden         (o_rden),
    .o_ii_req       (o_ii_req),
    .o_ii_x         (o_ii_x),
    .o_ii_y         (o_ii_y),
    .i_ii_valid     (i_ii_valid),
    .i_ii_data      (i_ii_data),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_stage_sum    (o_stage_sum)
  );

  function automatic logic [23:0] ii_val(input logic [11:0] x, input logic [11:0] y);
    if (x == 12'd6 && y == 12'd6) return 24'd10;
    if (x == 12'd8 && y == 12'd6) return 24'd20;
    if (x == 12'd6 && y == 12'd8) return 24'd30;
    if (x == 12'd8 && y == 12'd8) return 24'd100;
    return 24'(int'(x) * 37 + int'(y) * 1001);
  endfunction

  function automatic int leaf_of(input cls_t c, input logic [11:0] wx, input logic [11:0] wy);
    longint feat = 0;
    for (int r = 0; r < 3; r++) begin
      logic [11:0] ax, ay, bx, cy;
      logic [23:0] rs;
      int wt;
      wt = int'(signed'(c[5*r+4]));
      if (wt == 0 || c[5*r+2] == 12'd0 || c[5*r+3] == 12'd0) continue;
      ax = wx + c[5*r];
      ay = wy + c[5*r+1];
      bx = ax + c[5*r+2];
      cy = ay + c[5*r+3];
      rs = ii_val(bx, cy) - ii_val(bx, ay) - ii_val(ax, cy) + ii_val(ax, ay);
      feat += longint'(wt) * longint'(rs);
    end
    return (feat < longint'(signed'(c[15]))) ? int'(signed'(c[16])) : int'(signed'(c[17]));
  endfunction

  function automatic logic [19:0] acc(input logic [19:0] s, input int v);
    logic signed [19:0] w;
    int t;
    w = s;
    t = int'(w) + v;
`ifdef HAAR_EVAL_SATURATE_EN
    if (t > 524287) t = 524287;
    if (t < -524288) t = -524288;
`endif
    return 20'(t);
  endfunction

  function automatic exp_t model_exp(input logic [11:0] wx, input logic [11:0] wy, input logic [11:0] thr);
    exp_t e;
    logic [19:0] s;
    logic signed [19:0] ss;
    s = '0;
    foreach (cls_q[k]) s = acc(s, leaf_of(cls_q[k], wx, wy));
    ss = s;
    e.sum = s;
    e.pass = int'(ss) >= int'(signed'(thr));
    return e;
  endfunction

  // integral-image responder: 0..2 cycle latency, one request at a time
  initial forever begin
    @(posedge clk_fpga); #1;
    if (i_ii_valid) begin
      i_ii_valid = 0;
    end else if (o_ii_req) begin
      if (dly == 0) begin
        i_ii_valid = 1;
        i_ii_data = ii_val(o_ii_x, o_ii_y);
        dly = $urandom_range(0, 2);
      end else begin
        dly--;
      end
    end
  end

  initial forever begin
    @(negedge clk_fpga);
    if (o_ii_req && i_ii_valid) hs_cnt++;
    if (o_done) done_cnt++;
    if (o_rden && !i_data_valid) rden_viol++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [11:0] d, input logic e, input bit gap);
    int t = 0;
    if (gap) begin
      i_data_valid = 0;
      @(posedge clk_fpga); #1;
    end
    i_data = d;
    i_end_database = e;
    i_data_valid = 1;
    forever begin
      @(negedge clk_fpga);
      if (o_rden) break;
      t++;
      if (t > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL rden_wait got=0 want=1");
        break;
      end
    end
    @(posedge clk_fpga); #1;
    i_data_valid = 0;
    i_end_database = 0;
  endtask

  task automatic start_win(input logic [11:0] wx, input logic [11:0] wy);
    i_win_x = wx;
    i_win_y = wy;
    i_start = 1;
    @(posedge clk_fpga); #1;
    i_start = 0;
  endtask

  task automatic send_cls(input cls_t c, input bit gap);
    for (int j = 0; j < 18; j++) send_word(c[j], 1'b0, gap);
  endtask

  task automatic run_stage(input logic [11:0] wx, input logic [11:0] wy, input logic [11:0] thr, input bit gap);
    start_win(wx, wy);
    foreach (cls_q[k]) send_cls(cls_q[k], gap);
    send_word(thr, 1'b1, gap);
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_fpga);
      got = o_done;
    end
    @(posedge clk_fpga); #1;
  endtask

  task automatic test_reset;
    reset_fpga = 0;
    repeat (3) @(posedge clk_fpga);
    @(negedge clk_fpga);
    n_cmp++;
    if ({o_busy, o_done, o_pass, o_rden, o_ii_req} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got=%b want=00000", {o_busy, o_done, o_pass, o_rden, o_ii_req});
    end
    n_cmp++;
    if ({o_stage_sum, o_ii_x, o_ii_y} !== 44'b0) begin
      n_bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", o_stage_sum, o_ii_x, o_ii_y);
    end
    @(posedge clk_fpga); #1;
    reset_fpga = 1;
    @(posedge clk_fpga); #1;
  endtask

  task automatic test_threshold;
    for (int k = 0; k < 2; k++) begin
      bit got;
      exp_t e;
      int d0;
      logic [11:0] thr;
      thr = (k == 0) ? 12'd7 : 12'd8;
      cls_q.delete();
      cls_q.push_back(cls_a);
      e.pass = (k == 0);
      e.sum = 20'd7;
      sb.push_back(e);
      d0 = done_cnt;
      run_stage(12'd5, 12'd5, thr, 1'b0);
      wait_done(got);
      e = sb.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL thr_done got=0 want=1"); end
      n_cmp++;
      if (o_pass !== e.pass) begin n_bad++; $display("FAIL thr_pass got=%b want=%b", o_pass, e.pass); end
      n_cmp++;
      if (o_stage_sum !== e.sum) begin n_bad++; $display("FAIL thr_sum got=%0d want=%0d", o_stage_sum, e.sum); end
      repeat (3) @(posedge clk_fpga);
      #1;
      n_cmp++;
      if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL thr_done_cnt got=%0d want=1", done_cnt - d0); end
      n_cmp++;
      if (o_busy !== 1'b0 || o_pass !== e.pass) begin
        n_bad++; $display("FAIL thr_hold got=%b%b want=0%b", o_busy, o_pass, e.pass);
      end
    end
  endtask

  task automatic test_skip;
    bit got;
    exp_t e;
    int h0;
    cls_q.delete();
    cls_q.push_back(cls_a);
    cls_q.push_back(cls_a2);
    sb.push_back(model_exp(12'd5, 12'd5, 12'hFF0));
    h0 = hs_cnt;
    run_stage(12'd5, 12'd5, 12'hFF0, 1'b0);
    wait_done(got);
    e = sb.pop_front();
    n_cmp++;
    if (hs_cnt - h0 !== 8) begin n_bad++; $display("FAIL skip_handshakes got=%0d want=8", hs_cnt - h0); end
    n_cmp++;
    if (!got || o_stage_sum !== e.sum) begin
      n_bad++; $display("FAIL skip_sum got=%0d want=%0d", o_stage_sum, e.sum);
    end
    n_cmp++;
    if (o_pass !== e.pass) begin n_bad++; $display("FAIL skip_pass got=%b want=%b", o_pass, e.pass); end
  endtask

  task automatic test_stall;
    bit got;
    exp_t e;
    logic [19:0] cont_sum;
    cls_q.delete();
    cls_q.push_back(cls_a);
    cls_q.push_back(cls_b);
    for (int g = 0; g < 2; g++) begin
      sb.push_back(model_exp(12'd5, 12'd5, 12'd0));
      run_stage(12'd5, 12'd5, 12'd0, g[0]);
      wait_done(got);
      e = sb.pop_front();
      n_cmp++;
      if (!got || o_stage_sum !== e.sum || o_pass !== e.pass) begin
        n_bad++; $display("FAIL stall_result_%0d got=%0d/%b want=%0d/%b", g, o_stage_sum, o_pass, e.sum, e.pass);
      end
      if (g == 0) cont_sum = e.sum;
    end
    n_cmp++;
    if (o_stage_sum !== cont_sum) begin n_bad++; $display("FAIL stall_vs_cont got=%0d want=%0d", o_stage_sum, cont_sum); end
    n_cmp++;
    if (rden_viol !== 0) begin n_bad++; $display("FAIL rden_no_valid got=%0d want=0", rden_viol); end
  endtask

  task automatic test_reset_mid;
    bit seen, got;
    exp_t e;
    int d0;
    start_win(12'd5, 12'd5);
    send_cls(cls_a, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_fpga);
      seen = o_ii_req;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL mid_fetch_req got=0 want=1"); end
    @(posedge clk_fpga); #1;
    reset_fpga = 0;
    d0 = done_cnt;
    @(posedge clk_fpga);
    @(negedge clk_fpga);
    n_cmp++;
    if ({o_busy, o_ii_req, o_done} !== 3'b0) begin
      n_bad++; $display("FAIL mid_reset got=%b want=000", {o_busy, o_ii_req, o_done});
    end
    @(posedge clk_fpga); #1;
    reset_fpga = 1;
    repeat (5) @(posedge clk_fpga);
    #1;
    n_cmp++;
    if (done_cnt !== d0) begin n_bad++; $display("FAIL mid_no_done got=%0d want=%0d", done_cnt, d0); end
    cls_q.delete();
    cls_q.push_back(cls_a);
    e.pass = 1'b1;
    e.sum = 20'd7;
    sb.push_back(e);
    run_stage(12'd5, 12'd5, 12'd7, 1'b0);
    wait_done(got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || o_stage_sum !== e.sum || o_pass !== e.pass) begin
      n_bad++; $display("FAIL mid_rerun got=%0d/%b want=%0d/%b", o_stage_sum, o_pass, e.sum, e.pass);
    end
  endtask

  task automatic test_saturate;
    bit got;
    exp_t e;
    cls_q.delete();
    for (int k = 0; k < 260; k++) cls_q.push_back(cls_s);
    sb.push_back(model_exp(12'd0, 12'd0, 12'd0));
    run_stage(12'd0, 12'd0, 12'd0, 1'b0);
    wait_done(got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || o_stage_sum !== e.sum) begin
      n_bad++; $display("FAIL sat_sum got=%0d want=%0d", o_stage_sum, e.sum);
    end
    n_cmp++;
    if (o_pass !== e.pass) begin n_bad++; $display("FAIL sat_pass got=%b want=%b", o_pass, e.pass); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_skip();
    test_stall();
    test_reset_mid();
    test_saturate();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
